// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller interface for the three-stage pipeline.
// Groups the fetch-stage instruction fields, the branch resolution input
// and every controller output into one bundle.
//   master : pipeline side (drives F fields and e_branch_taken, reads controls)
//   slave  : hazard controller (reads F fields, drives controls and counters)
// Signals:
//   f_valid, f_rs1, f_rs2, f_use_rs1, f_use_rs2, f_rd, f_wen, f_is_load
//   e_branch_taken
//   pc_hold, fe_bubble, fwd_rs1_sel, fwd_rs2_sel, busy_flush
//   stall_cnt, flush_cnt (CNT_W bits, wrap around)
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             f_valid;
  logic [4:0]       f_rs1;
  logic [4:0]       f_rs2;
  logic             f_use_rs1;
  logic             f_use_rs2;
  logic [4:0]       f_rd;
  logic             f_wen;
  logic             f_is_load;
  logic             e_branch_taken;
  logic             pc_hold;
  logic             fe_bubble;
  logic [1:0]       fwd_rs1_sel;
  logic [1:0]       fwd_rs2_sel;
  logic             busy_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output f_valid, f_rs1, f_rs2, f_use_rs1, f_use_rs2, f_rd, f_wen, f_is_load,
    output e_branch_taken,
    input  pc_hold, fe_bubble, fwd_rs1_sel, fwd_rs2_sel, busy_flush,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  f_valid, f_rs1, f_rs2, f_use_rs1, f_use_rs2, f_rd, f_wen, f_is_load,
    input  e_branch_taken,
    output pc_hold, fe_bubble, fwd_rs1_sel, fwd_rs2_sel, busy_flush,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the F/E/W pipeline.
// Shadows rd/wen/load of the instructions in E and W, drives the ALU
// forwarding selects, stalls one cycle on load-use, and injects
// FLUSH_CYCLES bubbles after a taken branch. Counts stall cycles and
// taken-branch events.
// Ports:
//   clk   : pipeline clock, rising edge
//   reset : asynchronous, active-high, clears all state
//   hz    : pipe_hazard_ctrl_if slave modport (F fields in, controls out)
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  pipe_hazard_ctrl_if.slave   hz
);

  typedef enum logic [1:0] {RUN, LSTALL, FLUSH} state_t;

  state_t           state;
  logic [2:0]       fl_left;
  logic             e_valid, e_wen, e_load;
  logic [4:0]       e_rd;
  logic             w_valid, w_wen;
  logic [4:0]       w_rd;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  logic             e_live, w_live, branch, hazard;
  logic             pc_hold, fe_bubble;
  logic [1:0]       sel1, sel2;

  // E beats W; a load still in E cannot forward (its data is not ready).
  function automatic logic [1:0] fwd_sel(
    input logic       use_s,
    input logic [4:0] rs,
    input logic       el,
    input logic       eld,
    input logic [4:0] erd,
    input logic       wl,
    input logic [4:0] wrd
  );
    logic [1:0] s;
    s = 2'd0;
    if (use_s) begin
      if (el && !eld && erd == rs)
        s = 2'd1;
      else if (wl && wrd == rs)
        s = 2'd2;
    end
    return s;
  endfunction

  // Register 0 is excluded here, so it never forwards and never stalls.
  assign e_live = e_valid && e_wen && (e_rd != 5'd0);
  assign w_live = w_valid && w_wen && (w_rd != 5'd0);
  assign branch = hz.e_branch_taken && e_valid;
  assign hazard = hz.f_valid && e_live && e_load &&
                  ((hz.f_use_rs1 && e_rd == hz.f_rs1) ||
                   (hz.f_use_rs2 && e_rd == hz.f_rs2));

  always_comb begin
    sel1 = fwd_sel(hz.f_use_rs1, hz.f_rs1, e_live, e_load, e_rd, w_live, w_rd);
    sel2 = fwd_sel(hz.f_use_rs2, hz.f_rs2, e_live, e_load, e_rd, w_live, w_rd);
  end

  // Taken branch outranks load-use: the wrong-path F instruction is dropped.
  always_comb begin
    pc_hold   = 1'b0;
    fe_bubble = 1'b0;
    case (state)
      RUN: begin
        if (branch) begin
          fe_bubble = 1'b1;
        end else if (hazard) begin
          pc_hold   = 1'b1;
          fe_bubble = 1'b1;
        end
      end
      FLUSH:   fe_bubble = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      fl_left   <= 3'd0;
      e_valid   <= 1'b0;
      e_wen     <= 1'b0;
      e_load    <= 1'b0;
      e_rd      <= 5'd0;
      w_valid   <= 1'b0;
      w_wen     <= 1'b0;
      w_rd      <= 5'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      // E -> W boundary
      w_valid <= e_valid;
      w_wen   <= e_wen;
      w_rd    <= e_rd;
      // F -> E boundary
      if (fe_bubble) begin
        e_valid <= 1'b0;
        e_wen   <= 1'b0;
        e_load  <= 1'b0;
        e_rd    <= 5'd0;
      end else begin
        e_valid <= hz.f_valid;
        e_wen   <= hz.f_wen;
        e_load  <= hz.f_is_load;
        e_rd    <= hz.f_rd;
      end

      case (state)
        RUN: begin
          if (branch) begin
            flush_cnt <= flush_cnt + 1'b1;
            fl_left   <= 3'(FLUSH_CYCLES - 1);
            state     <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
          end else if (hazard) begin
            stall_cnt <= stall_cnt + 1'b1;
            state     <= LSTALL;
          end
        end
        LSTALL: state <= RUN;
        FLUSH: begin
          // The bubble of the resolving cycle was already counted in RUN.
          fl_left <= fl_left - 3'd1;
          if (fl_left <= 3'd1)
            state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign hz.pc_hold     = pc_hold;
  assign hz.fe_bubble   = fe_bubble;
  assign hz.fwd_rs1_sel = sel1;
  assign hz.fwd_rs2_sel = sel2;
  assign hz.busy_flush  = (state == FLUSH);
  assign hz.stall_cnt   = stall_cnt;
  assign hz.flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl. Instance u1 uses FLUSH_CYCLES=2,
// CNT_W=16 for the forwarding/stall/flush scenarios; instance u2 uses
// FLUSH_CYCLES=1, CNT_W=4 for counter wrap, async reset mid-stall and
// branch-over-stall priority.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic rst2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(16)) hz1 ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  hz2 ();

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) u1 (
    .clk   (clk),
    .reset (reset),
    .hz    (hz1)
  );

  pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) u2 (
    .clk   (clk),
    .reset (rst2),
    .hz    (hz2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // valid, rs1, rs2, use_rs1, use_rs2, rd, wen, load
  task automatic set_f1(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1s, input logic u2s, input logic [4:0] rd,
                        input logic wen, input logic ld);
    hz1.f_valid   = v;
    hz1.f_rs1     = rs1;
    hz1.f_rs2     = rs2;
    hz1.f_use_rs1 = u1s;
    hz1.f_use_rs2 = u2s;
    hz1.f_rd      = rd;
    hz1.f_wen     = wen;
    hz1.f_is_load = ld;
  endtask

  initial begin
    reset = 1'b1;
    rst2  = 1'b1;
    hz1.e_branch_taken = 1'b0;
    set_f1(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    // u2: lw x9,0(x9) held in F for the whole run
    hz2.f_valid   = 1'b1;
    hz2.f_rs1     = 5'd9;
    hz2.f_rs2     = 5'd0;
    hz2.f_use_rs1 = 1'b1;
    hz2.f_use_rs2 = 1'b0;
    hz2.f_rd      = 5'd9;
    hz2.f_wen     = 1'b1;
    hz2.f_is_load = 1'b1;
    hz2.e_branch_taken = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_pc_hold",   32'(hz1.pc_hold), 32'd0);
    check("rst_fe_bubble", 32'(hz1.fe_bubble), 32'd0);
    check("rst_sel1",      32'(hz1.fwd_rs1_sel), 32'd0);
    check("rst_sel2",      32'(hz1.fwd_rs2_sel), 32'd0);
    check("rst_busy",      32'(hz1.busy_flush), 32'd0);
    check("rst_stall_cnt", 32'(hz1.stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(hz1.flush_cnt), 32'd0);
    reset = 1'b0;

    // Back-to-back: add x5,x1,x2 ; sub x6,x5,x1
    set_f1(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    #1;
    check("b2b_first_sel1", 32'(hz1.fwd_rs1_sel), 32'd0);
    tick();
    set_f1(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    check("b2b_sel1",      32'(hz1.fwd_rs1_sel), 32'd1);
    check("b2b_sel2",      32'(hz1.fwd_rs2_sel), 32'd0);
    check("b2b_pc_hold",   32'(hz1.pc_hold), 32'd0);
    check("b2b_stall_cnt", 32'(hz1.stall_cnt), 32'd0);
    tick();

    // Two apart: add x5 ; nop ; or x7,x5,x5
    set_f1(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    set_f1(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    set_f1(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    #1;
    check("two_sel1", 32'(hz1.fwd_rs1_sel), 32'd2);
    check("two_sel2", 32'(hz1.fwd_rs2_sel), 32'd2);
    tick();

    // Load-use: lw x9,0(x1) ; add x3,x9,x2
    set_f1(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
    tick();
    set_f1(1'b1, 5'd9, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    #1;
    check("lu_pc_hold",   32'(hz1.pc_hold), 32'd1);
    check("lu_fe_bubble", 32'(hz1.fe_bubble), 32'd1);
    check("lu_sel1",      32'(hz1.fwd_rs1_sel), 32'd0);
    tick();
    check("lu2_pc_hold",   32'(hz1.pc_hold), 32'd0);
    check("lu2_fe_bubble", 32'(hz1.fe_bubble), 32'd0);
    check("lu2_sel1",      32'(hz1.fwd_rs1_sel), 32'd2);
    check("lu2_sel2",      32'(hz1.fwd_rs2_sel), 32'd0);
    check("lu2_stall_cnt", 32'(hz1.stall_cnt), 32'd1);
    tick();

    // x0 destination: lw x0 ; add x3,x0,x0
    set_f1(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    set_f1(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    #1;
    check("x0_pc_hold", 32'(hz1.pc_hold), 32'd0);
    check("x0_sel1",    32'(hz1.fwd_rs1_sel), 32'd0);
    check("x0_sel2",    32'(hz1.fwd_rs2_sel), 32'd0);
    tick();

    // Taken branch with lw x9 / add x3,x9 behind it
    set_f1(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    tick();
    hz1.e_branch_taken = 1'b1;
    set_f1(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
    #1;
    check("br0_fe_bubble", 32'(hz1.fe_bubble), 32'd1);
    check("br0_pc_hold",   32'(hz1.pc_hold), 32'd0);
    check("br0_busy",      32'(hz1.busy_flush), 32'd0);
    tick();
    set_f1(1'b1, 5'd9, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    #1;
    check("br1_fe_bubble", 32'(hz1.fe_bubble), 32'd1);
    check("br1_busy",      32'(hz1.busy_flush), 32'd1);
    check("br1_pc_hold",   32'(hz1.pc_hold), 32'd0);
    check("br1_flush_cnt", 32'(hz1.flush_cnt), 32'd1);
    tick();
    hz1.e_branch_taken = 1'b0;
    #1;
    check("br2_fe_bubble", 32'(hz1.fe_bubble), 32'd0);
    check("br2_busy",      32'(hz1.busy_flush), 32'd0);
    check("br2_flush_cnt", 32'(hz1.flush_cnt), 32'd1);
    check("br2_stall_cnt", 32'(hz1.stall_cnt), 32'd1);
    tick();

    // Invalid F instruction never stalls
    set_f1(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
    tick();
    set_f1(1'b0, 5'd9, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    #1;
    check("inv_pc_hold",   32'(hz1.pc_hold), 32'd0);
    check("inv_fe_bubble", 32'(hz1.fe_bubble), 32'd0);
    tick();

    // u2: back-to-back dependent loads, one stall per two cycles
    rst2 = 1'b0;
    repeat (30) tick();
    check("u2_cnt15",     32'(hz2.stall_cnt), 32'd15);
    check("u2_lst_hold",  32'(hz2.pc_hold), 32'd0);
    check("u2_lst_sel1",  32'(hz2.fwd_rs1_sel), 32'd2);
    #2;
    rst2 = 1'b1;
    #1;
    check("u2_rst_cnt",    32'(hz2.stall_cnt), 32'd0);
    check("u2_rst_hold",   32'(hz2.pc_hold), 32'd0);
    check("u2_rst_bubble", 32'(hz2.fe_bubble), 32'd0);
    check("u2_rst_sel1",   32'(hz2.fwd_rs1_sel), 32'd0);
    check("u2_rst_busy",   32'(hz2.busy_flush), 32'd0);
    tick();
    rst2 = 1'b0;
    repeat (30) tick();
    check("u2_cnt15b", 32'(hz2.stall_cnt), 32'd15);
    tick();
    check("u2_hold_again", 32'(hz2.pc_hold), 32'd1);
    tick();
    check("u2_wrap_cnt", 32'(hz2.stall_cnt), 32'd0);
    tick();
    hz2.e_branch_taken = 1'b1;
    #1;
    check("u2_prio_bubble", 32'(hz2.fe_bubble), 32'd1);
    check("u2_prio_hold",   32'(hz2.pc_hold), 32'd0);
    tick();
    hz2.e_branch_taken = 1'b0;
    #1;
    check("u2_fc1_flush_cnt", 32'(hz2.flush_cnt), 32'd1);
    check("u2_fc1_stall_cnt", 32'(hz2.stall_cnt), 32'd0);
    check("u2_fc1_busy",      32'(hz2.busy_flush), 32'd0);
    check("u2_fc1_bubble",    32'(hz2.fe_bubble), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
